reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement queue of the out-of-order core: allocates a rename tag per issued instruction, collects results from the ALU and LSB broadcast buses, and commits results in program order to the register file through the `rob_to_rf_*` port. It also detects branch mispredictions at the head and raises the global flush. ROB index 0 is reserved as "no dependency", so usable entries are 1..2^ROB_WIDTH-1.

## Interface
- ROB_WIDTH, 3, tag width; capacity N = 2^ROB_WIDTH-1 entries.
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  when low, all state and registered outputs hold.
- issue_valid  in  1  allocate the entry at the tail this cycle.
- issue_rd_id  in  5  destination register; 0 means no register write.
- issue_is_branch  in  1  entry is a conditional branch.
- issue_is_store  in  1  entry is a store.
- issue_pred_taken  in  1  predicted direction.
- issue_alt_pc  in  32  recovery PC if the prediction is wrong.
- issue_rob_index  out  W  tail index; valid whenever rob_full=0.
- rob_full  out  1  count==N.
- alu_valid, alu_rob_index, alu_val, alu_taken  in  1/W/32/1  ALU broadcast.
- lsb_valid, lsb_rob_index, lsb_val  in  1/W/32  LSB broadcast.
- qry1_index, qry2_index  in  W  operand tags being resolved by the issue unit.
- qry1_ready, qry2_ready  out  1  the tag's value is available.
- qry1_val, qry2_val  out  32  the tag's value.
- rob_to_rf_ready  out  1  single-cycle commit strobe.
- rob_to_rf_reg_id  out  5  committed rd.
- rob_to_rf_reg_val  out  32  committed value.
- rob_to_rf_rob_index  out  W  committed tag.
- rob_to_lsb_commit  out  1  the head store is committed; release it to memory.
- clr_out  out  1  single-cycle flush strobe.
- clr_pc  out  32  fetch redirect target.

## Operation
- Per entry: busy, ready, rd, val, is_branch, is_store, pred_taken, taken, alt_pc.
- Head and tail are pointers over 1..N. Increment wraps from N to 1 and never takes the value 0.
- Issue: if issue_valid and not full, write the tail entry (busy=1, ready=0) and advance tail. Issue while full is ignored (protocol error).
- Writeback: each valid bus with a busy matching index sets ready=1 and stores val (ALU also stores taken). ALU and LSB to the same index in one cycle is illegal. Writes to idle entries are ignored.
- Query, combinational:
  - index 0: ready=1, val=0.
  - Otherwise ready = entry.ready OR a same-cycle bus match, with the bus value bypassed. ALU has priority over LSB.
- Commit: at most one per cycle, when the head is busy and ready at the start of the cycle.
  - Non-branch: pulse rob_to_rf_ready with rd/val/index (rd=0 is still pulsed; the RF ignores it). Pulse rob_to_lsb_commit if the entry is a store. Free the head and advance.
  - Branch with taken==pred_taken: retire silently.
  - Branch with taken!=pred_taken: pulse clr_out with clr_pc=alt_pc. Next state: all entries idle, head=tail=1, count=0. Any issue or writeback in that cycle is discarded.
- Count: +1 on accepted issue, −1 on commit, unchanged when both occur. Cleared on flush.

## Timing
- Reset (async):
  - All entries idle; head=tail=1; count=0.
  - rob_to_rf_*, rob_to_lsb_commit, clr_out, clr_pc = 0.
  - issue_rob_index=1; rob_full=0.
- Issue at edge k: the tag is visible to query and writeback from cycle k+1.
- Writeback at edge k: the entry can commit at edge k+1. The commit strobe is registered and is high during cycle k+1..k+2.
- Commit outputs and clr_out are registered and high for exactly one enabled cycle. They are held, not re-evaluated, while rdy_in=0.
- Issue and commit in the same cycle are allowed when full: the issue is rejected because rob_full is from registered count, while the commit proceeds.
- The freed slot is reusable the cycle after commit.

## Structure
- Shared package: ROB_WIDTH default, ROB_NULL=0 constant, entry struct type, and a pointer-increment function with wrap-to-1.
- Optional sub-module `rob_query_port`, instantiated twice: tag lookup plus two-bus bypass. The rest is a single always block.

## Test plan
- ROB_WIDTH=3:
  - Reset, then issue 7 entries → tags 1..7 and rob_full=1.
  - An 8th issue is ignored.
  - Commit 1, then issue → tag 1 is reused.
- Issue rd=5 tag 1; ALU writeback val=0x1234 at the same edge as query qry1_index=1 → qry1_ready=1, qry1_val=0x1234. One cycle later, rob_to_rf_ready=1, reg_id=5, val=0x1234, index=1.
- Results arrive out of order for tags 3, 2, 1 → commits occur in order 1, 2, 3 on consecutive cycles.
- Branch tag 2 with pred=0, ALU taken=1, alt_pc=0x100; younger tag 3 is ready → clr_out pulses with clr_pc=0x100; tag 3 never commits; next issue gets tag 1.
- Store tag 1 → rob_to_lsb_commit pulses together with rob_to_rf_ready (rd=0).
- Assert rst_in mid-queue (async, between edges) → outputs are 0 immediately and the next issue gets tag 1.
- Hold rdy_in=0 for 3 cycles with ALU traffic → no state change and no strobes are repeated.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// ----------------------------------------------------------------------------
// reorder_buffer_pkg : shared types, constants and pointer helper for the ROB
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package reorder_buffer_pkg;

   localparam int ROB_WIDTH_DEFAULT = 3;
   localparam int ROB_NULL          = 0;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic [4:0]  rd;
      logic [31:0] val;
      logic        is_branch;
      logic        is_store;
      logic        pred_taken;
      logic        taken;
      logic [31:0] alt_pc;
   } rob_entry_t;

   // Slot 0 is the "no dependency" tag, so pointers wrap from cap back to 1.
   function automatic int ptr_inc(input int ptr, input int cap);
      return (ptr >= cap) ? 1 : ptr + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_query_port.sv
// ----------------------------------------------------------------------------
// rob_query_port : operand tag lookup with ALU/LSB same-cycle bypass
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rob_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
   input  logic [ROB_WIDTH-1:0]                 qry_index,
   input  logic [(1<<ROB_WIDTH)-1:0]            busy_vec,
   input  logic [(1<<ROB_WIDTH)-1:0]            ready_vec,
   input  logic [(1<<ROB_WIDTH)-1:0][31:0]      val_vec,
   input  logic                                 alu_valid,
   input  logic [ROB_WIDTH-1:0]                 alu_rob_index,
   input  logic [31:0]                          alu_val,
   input  logic                                 lsb_valid,
   input  logic [ROB_WIDTH-1:0]                 lsb_rob_index,
   input  logic [31:0]                          lsb_val,
   output logic                                 qry_ready,
   output logic [31:0]                          qry_val
);

   always_comb begin
      qry_ready = ready_vec[qry_index];
      qry_val   = val_vec[qry_index];
      if (qry_index == ROB_WIDTH'(ROB_NULL)) begin
         qry_ready = 1'b1;
         qry_val   = '0;
      end else if (alu_valid && (alu_rob_index == qry_index) && busy_vec[qry_index]) begin
         qry_ready = 1'b1;
         qry_val   = alu_val;
      end else if (lsb_valid && (lsb_rob_index == qry_index) && busy_vec[qry_index]) begin
         qry_ready = 1'b1;
         qry_val   = lsb_val;
      end
   end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer : in-order retirement queue with writeback, commit and flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd_id,
   input  logic                 issue_is_branch,
   input  logic                 issue_is_store,
   input  logic                 issue_pred_taken,
   input  logic [31:0]          issue_alt_pc,
   output logic [ROB_WIDTH-1:0] issue_rob_index,
   output logic                 rob_full,
   input  logic                 alu_valid,
   input  logic [ROB_WIDTH-1:0] alu_rob_index,
   input  logic [31:0]          alu_val,
   input  logic                 alu_taken,
   input  logic                 lsb_valid,
   input  logic [ROB_WIDTH-1:0] lsb_rob_index,
   input  logic [31:0]          lsb_val,
   input  logic [ROB_WIDTH-1:0] qry1_index,
   input  logic [ROB_WIDTH-1:0] qry2_index,
   output logic                 qry1_ready,
   output logic                 qry2_ready,
   output logic [31:0]          qry1_val,
   output logic [31:0]          qry2_val,
   output logic                 rob_to_rf_ready,
   output logic [4:0]           rob_to_rf_reg_id,
   output logic [31:0]          rob_to_rf_reg_val,
   output logic [ROB_WIDTH-1:0] rob_to_rf_rob_index,
   output logic                 rob_to_lsb_commit,
   output logic                 clr_out,
   output logic [31:0]          clr_pc
);

   localparam int                 c_n_ent   = (1 << ROB_WIDTH) - 1;
   localparam logic [ROB_WIDTH-1:0] c_n_idx = ROB_WIDTH'(c_n_ent);
   localparam logic [ROB_WIDTH-1:0] c_one   = ROB_WIDTH'(1);

   rob_entry_t            entries_q [0:c_n_ent];
   rob_entry_t            entries_d [0:c_n_ent];
   logic [ROB_WIDTH-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic                  rf_ready_q, rf_ready_d, lsb_commit_q, lsb_commit_d, clr_q, clr_d;
   logic [4:0]            rf_reg_id_q, rf_reg_id_d;
   logic [31:0]           rf_reg_val_q, rf_reg_val_d, clr_pc_q, clr_pc_d;
   logic [ROB_WIDTH-1:0]  rf_idx_q, rf_idx_d;

   rob_entry_t            head_e;
   logic                  do_commit, mispredict, issue_ok;
   logic [c_n_ent:0]      busy_vec, ready_vec;
   logic [c_n_ent:0][31:0] val_vec;

   for (genvar g = 0; g <= c_n_ent; g++) begin : g_vec
      assign busy_vec[g]  = entries_q[g].busy;
      assign ready_vec[g] = entries_q[g].ready;
      assign val_vec[g]   = entries_q[g].val;
   end

   always_comb begin
      entries_d    = entries_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      rf_ready_d   = 1'b0;
      lsb_commit_d = 1'b0;
      clr_d        = 1'b0;
      rf_reg_id_d  = rf_reg_id_q;
      rf_reg_val_d = rf_reg_val_q;
      rf_idx_d     = rf_idx_q;
      clr_pc_d     = clr_pc_q;

      head_e     = entries_q[head_q];
      do_commit  = head_e.busy && head_e.ready;
      mispredict = do_commit && head_e.is_branch && (head_e.taken != head_e.pred_taken);
      issue_ok   = issue_valid && (count_q != c_n_idx);

      if (mispredict) begin
         // Flush wipes everything, including this cycle's issue and writebacks.
         for (int i = 0; i <= c_n_ent; i++) entries_d[i] = '0;
         head_d   = c_one;
         tail_d   = c_one;
         count_d  = '0;
         clr_d    = 1'b1;
         clr_pc_d = head_e.alt_pc;
      end else begin
         if (alu_valid && entries_q[alu_rob_index].busy) begin
            entries_d[alu_rob_index].ready = 1'b1;
            entries_d[alu_rob_index].val   = alu_val;
            entries_d[alu_rob_index].taken = alu_taken;
         end
         if (lsb_valid && entries_q[lsb_rob_index].busy) begin
            entries_d[lsb_rob_index].ready = 1'b1;
            entries_d[lsb_rob_index].val   = lsb_val;
         end
         if (do_commit) begin
            entries_d[head_q] = '0;
            head_d = ROB_WIDTH'(ptr_inc(int'(head_q), c_n_ent));
            if (!head_e.is_branch) begin
               rf_ready_d   = 1'b1;
               rf_reg_id_d  = head_e.rd;
               rf_reg_val_d = head_e.val;
               rf_idx_d     = head_q;
               lsb_commit_d = head_e.is_store;
            end
         end
         if (issue_ok) begin
            entries_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: issue_rd_id, val: 32'd0,
                                  is_branch: issue_is_branch, is_store: issue_is_store,
                                  pred_taken: issue_pred_taken, taken: 1'b0,
                                  alt_pc: issue_alt_pc};
            tail_d = ROB_WIDTH'(ptr_inc(int'(tail_q), c_n_ent));
         end
         count_d = count_q + ROB_WIDTH'(issue_ok) - ROB_WIDTH'(do_commit);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i <= c_n_ent; i++) entries_q[i] <= '0;
         head_q       <= c_one;
         tail_q       <= c_one;
         count_q      <= '0;
         rf_ready_q   <= 1'b0;
         rf_reg_id_q  <= '0;
         rf_reg_val_q <= '0;
         rf_idx_q     <= '0;
         lsb_commit_q <= 1'b0;
         clr_q        <= 1'b0;
         clr_pc_q     <= '0;
      end else if (rdy_in) begin
         entries_q    <= entries_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         rf_ready_q   <= rf_ready_d;
         rf_reg_id_q  <= rf_reg_id_d;
         rf_reg_val_q <= rf_reg_val_d;
         rf_idx_q     <= rf_idx_d;
         lsb_commit_q <= lsb_commit_d;
         clr_q        <= clr_d;
         clr_pc_q     <= clr_pc_d;
      end
   end

   rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_qry1 (
      .qry_index(qry1_index), .busy_vec(busy_vec), .ready_vec(ready_vec), .val_vec(val_vec),
      .alu_valid(alu_valid), .alu_rob_index(alu_rob_index), .alu_val(alu_val),
      .lsb_valid(lsb_valid), .lsb_rob_index(lsb_rob_index), .lsb_val(lsb_val),
      .qry_ready(qry1_ready), .qry_val(qry1_val)
   );

   rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_qry2 (
      .qry_index(qry2_index), .busy_vec(busy_vec), .ready_vec(ready_vec), .val_vec(val_vec),
      .alu_valid(alu_valid), .alu_rob_index(alu_rob_index), .alu_val(alu_val),
      .lsb_valid(lsb_valid), .lsb_rob_index(lsb_rob_index), .lsb_val(lsb_val),
      .qry_ready(qry2_ready), .qry_val(qry2_val)
   );

   assign issue_rob_index     = tail_q;
   assign rob_full            = (count_q == c_n_idx);
   assign rob_to_rf_ready     = rf_ready_q;
   assign rob_to_rf_reg_id    = rf_reg_id_q;
   assign rob_to_rf_reg_val   = rf_reg_val_q;
   assign rob_to_rf_rob_index = rf_idx_q;
   assign rob_to_lsb_commit   = lsb_commit_q;
   assign clr_out             = clr_q;
   assign clr_pc              = clr_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer : directed plus randomized checks against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reorder_buffer;

   localparam int W = 3;
   localparam int N = (1 << W) - 1;

   logic          clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
   logic          issue_valid, issue_is_branch, issue_is_store, issue_pred_taken;
   logic [4:0]    issue_rd_id;
   logic [31:0]   issue_alt_pc;
   logic [W-1:0]  issue_rob_index;
   logic          rob_full;
   logic          alu_valid, alu_taken, lsb_valid;
   logic [W-1:0]  alu_rob_index, lsb_rob_index, qry1_index, qry2_index;
   logic [31:0]   alu_val, lsb_val, qry1_val, qry2_val;
   logic          qry1_ready, qry2_ready;
   logic          rob_to_rf_ready, rob_to_lsb_commit, clr_out;
   logic [4:0]    rob_to_rf_reg_id;
   logic [31:0]   rob_to_rf_reg_val, clr_pc;
   logic [W-1:0]  rob_to_rf_rob_index;

   reorder_buffer #(.ROB_WIDTH(W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd_id(issue_rd_id), .issue_is_branch(issue_is_branch),
      .issue_is_store(issue_is_store), .issue_pred_taken(issue_pred_taken),
      .issue_alt_pc(issue_alt_pc), .issue_rob_index(issue_rob_index), .rob_full(rob_full),
      .alu_valid(alu_valid), .alu_rob_index(alu_rob_index), .alu_val(alu_val),
      .alu_taken(alu_taken), .lsb_valid(lsb_valid), .lsb_rob_index(lsb_rob_index),
      .lsb_val(lsb_val), .qry1_index(qry1_index), .qry2_index(qry2_index),
      .qry1_ready(qry1_ready), .qry2_ready(qry2_ready), .qry1_val(qry1_val),
      .qry2_val(qry2_val), .rob_to_rf_ready(rob_to_rf_ready),
      .rob_to_rf_reg_id(rob_to_rf_reg_id), .rob_to_rf_reg_val(rob_to_rf_reg_val),
      .rob_to_rf_rob_index(rob_to_rf_rob_index), .rob_to_lsb_commit(rob_to_lsb_commit),
      .clr_out(clr_out), .clr_pc(clr_pc)
   );

   always #5 clk_in = ~clk_in;

   // Program-order queue of in-flight instructions.
   typedef struct {
      int          tag;
      logic [4:0]  rd;
      logic [31:0] val;
      bit          ready, br, st, pred, taken;
      logic [31:0] alt;
   } ment_t;

   ment_t       q[$];
   int          next_tag;
   bit          e_rf, e_lsb, e_clr;
   logic [4:0]  e_rd;
   logic [31:0] e_val, e_pc;
   int          e_idx;
   int          n_checks = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      next_tag = 1;
      e_rf = 0; e_lsb = 0; e_clr = 0;
   endtask

   task automatic mquery(input int idx, output bit live, output bit rdy, output logic [31:0] val);
      live = 0; rdy = 0; val = '0;
      if (idx == 0) begin live = 1; rdy = 1; return; end
      foreach (q[i]) if (q[i].tag == idx) begin live = 1; rdy = q[i].ready; val = q[i].val; end
      if (live && alu_valid && int'(alu_rob_index) == idx) begin rdy = 1; val = alu_val; end
      else if (live && lsb_valid && int'(lsb_rob_index) == idx) begin rdy = 1; val = lsb_val; end
   endtask

   task automatic model_step();
      bit was_full;
      ment_t e;
      was_full = (q.size() == N);
      e_rf = 0; e_lsb = 0; e_clr = 0;
      if (q.size() > 0 && q[0].ready) begin
         if (q[0].br && q[0].taken != q[0].pred) begin
            e_clr = 1; e_pc = q[0].alt;
            q.delete(); next_tag = 1;
            return;
         end
         if (!q[0].br) begin
            e_rf = 1; e_rd = q[0].rd; e_val = q[0].val; e_idx = q[0].tag; e_lsb = q[0].st;
         end
         void'(q.pop_front());
      end
      foreach (q[i]) begin
         if (alu_valid && int'(alu_rob_index) == q[i].tag) begin
            q[i].ready = 1; q[i].val = alu_val; q[i].taken = alu_taken;
         end
         if (lsb_valid && int'(lsb_rob_index) == q[i].tag) begin
            q[i].ready = 1; q[i].val = lsb_val;
         end
      end
      if (issue_valid && !was_full) begin
         e = '{tag: next_tag, rd: issue_rd_id, val: 0, ready: 0, br: issue_is_branch,
               st: issue_is_store, pred: issue_pred_taken, taken: 0, alt: issue_alt_pc};
         q.push_back(e);
         next_tag = (next_tag == N) ? 1 : next_tag + 1;
      end
   endtask

   task automatic pre();
      bit live, rdy;
      logic [31:0] val;
      #1;
      if (q.size() < N) chk("issue_rob_index", 32'(issue_rob_index), 32'(next_tag));
      chk("rob_full", 32'(rob_full), 32'(q.size() == N));
      mquery(int'(qry1_index), live, rdy, val);
      if (live) begin
         chk("qry1_ready", 32'(qry1_ready), 32'(rdy));
         if (rdy) chk("qry1_val", qry1_val, val);
      end
      mquery(int'(qry2_index), live, rdy, val);
      if (live) begin
         chk("qry2_ready", 32'(qry2_ready), 32'(rdy));
         if (rdy) chk("qry2_val", qry2_val, val);
      end
   endtask

   task automatic post();
      if (rdy_in) model_step();
      @(posedge clk_in);
      #1;
      chk("rf_ready", 32'(rob_to_rf_ready), 32'(e_rf));
      chk("lsb_commit", 32'(rob_to_lsb_commit), 32'(e_lsb));
      chk("clr_out", 32'(clr_out), 32'(e_clr));
      if (e_rf) begin
         chk("rf_reg_id", 32'(rob_to_rf_reg_id), 32'(e_rd));
         chk("rf_reg_val", rob_to_rf_reg_val, e_val);
         chk("rf_rob_index", 32'(rob_to_rf_rob_index), 32'(e_idx));
      end
      if (e_clr) chk("clr_pc", clr_pc, e_pc);
   endtask

   task automatic tick(); pre(); post(); endtask

   task automatic set_idle();
      rdy_in = 1; issue_valid = 0; issue_rd_id = 0; issue_is_branch = 0; issue_is_store = 0;
      issue_pred_taken = 0; issue_alt_pc = 0; alu_valid = 0; alu_rob_index = 0; alu_val = 0;
      alu_taken = 0; lsb_valid = 0; lsb_rob_index = 0; lsb_val = 0; qry1_index = 0; qry2_index = 0;
   endtask

   task automatic drive_issue(input int rd, input bit br, input bit st, input bit pred, input int alt);
      issue_valid = 1; issue_rd_id = 5'(rd); issue_is_branch = br; issue_is_store = st;
      issue_pred_taken = pred; issue_alt_pc = 32'(alt);
   endtask

   task automatic drive_alu(input int idx, input int val, input bit tk);
      alu_valid = 1; alu_rob_index = W'(idx); alu_val = 32'(val); alu_taken = tk;
   endtask

   task automatic drive_lsb(input int idx, input int val);
      lsb_valid = 1; lsb_rob_index = W'(idx); lsb_val = 32'(val);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      #3;
      rst_in = 1;
      #1;
      chk("rst_rf_ready", 32'(rob_to_rf_ready), 0);
      chk("rst_lsb_commit", 32'(rob_to_lsb_commit), 0);
      chk("rst_clr_out", 32'(clr_out), 0);
      chk("rst_clr_pc", clr_pc, 0);
      chk("rst_reg_val", rob_to_rf_reg_val, 0);
      chk("rst_issue_idx", 32'(issue_rob_index), 1);
      chk("rst_full", 32'(rob_full), 0);
      model_reset();
      @(posedge clk_in);
      #2;
      rst_in = 0;
   endtask

   task automatic randomize_inputs();
      int cand[$];
      int k, kind;
      set_idle();
      rdy_in = ($urandom_range(9) != 0);
      if ($urandom_range(2) != 0) begin
         kind = $urandom_range(5);
         drive_issue((kind == 1) ? 0 : $urandom_range(31), kind == 0, kind == 1,
                     1'($urandom_range(1)), $urandom);
      end
      foreach (q[i]) if (!q[i].ready) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
         k = cand[$urandom_range(cand.size() - 1)];
         drive_alu(q[k].tag, $urandom, 1'($urandom_range(1)));
      end else if ($urandom_range(7) == 0) begin
         drive_alu($urandom_range(N), $urandom, 1'($urandom_range(1)));
      end
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
         k = cand[$urandom_range(cand.size() - 1)];
         if (!q[k].br && !(alu_valid && int'(alu_rob_index) == q[k].tag))
            drive_lsb(q[k].tag, $urandom);
      end
      qry1_index = W'($urandom_range(N));
      if (q.size() > 0) qry2_index = W'(q[$urandom_range(q.size() - 1)].tag);
   endtask

   initial begin
      set_idle();
      model_reset();
      repeat (2) @(posedge clk_in);
      #2;
      rst_in = 0;
      chk("init_issue_idx", 32'(issue_rob_index), 1);
      chk("init_full", 32'(rob_full), 0);
      chk("init_rf_ready", 32'(rob_to_rf_ready), 0);
      chk("init_clr_pc", clr_pc, 0);

      // Fill all seven slots, then try an eighth.
      for (int i = 1; i <= N; i++) begin
         drive_issue(i + 4, 0, 0, 0, 0);
         pre();
         chk("fill_tag", 32'(issue_rob_index), 32'(i));
         post();
         set_idle();
      end
      chk("full_lit", 32'(rob_full), 1);
      drive_issue(9, 0, 0, 0, 0);
      tick();
      set_idle();
      chk("model_size_after_8th", 32'(q.size()), 7);
      chk("full_after_8th", 32'(rob_full), 1);

      // Same-cycle bypass on query, then commit one cycle later.
      drive_alu(1, 32'h1234, 0);
      qry1_index = 1;
      pre();
      chk("qry1_bypass_ready", 32'(qry1_ready), 1);
      chk("qry1_bypass_val", qry1_val, 32'h1234);
      post();
      set_idle();
      drive_issue(10, 0, 0, 0, 0);
      tick();
      set_idle();
      chk("commit_lit_ready", 32'(rob_to_rf_ready), 1);
      chk("commit_lit_rd", 32'(rob_to_rf_reg_id), 5);
      chk("commit_lit_val", rob_to_rf_reg_val, 32'h1234);
      chk("commit_lit_idx", 32'(rob_to_rf_rob_index), 1);
      chk("reuse_tag", 32'(issue_rob_index), 1);
      drive_issue(11, 0, 0, 0, 0);
      tick();
      set_idle();

      // Async reset while a commit strobe is high.
      drive_alu(2, 32'h22, 0);
      tick(); set_idle();
      tick();
      chk("pre_reset_strobe", 32'(rob_to_rf_rob_index), 2);
      do_reset();

      // Out-of-order completion, in-order commit.
      for (int i = 0; i < 3; i++) begin drive_issue(i + 1, 0, 0, 0, 0); tick(); set_idle(); end
      drive_alu(3, 32'h33, 0); tick(); set_idle();
      drive_lsb(2, 32'h22);    tick(); set_idle();
      drive_alu(1, 32'h11, 0); tick(); set_idle();
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("ooo_commit_idx", 32'(rob_to_rf_rob_index), 32'(i));
      end

      // Mispredicted branch at the head flushes the younger ready entry.
      do_reset();
      drive_issue(1, 0, 0, 0, 0);      tick(); set_idle();
      drive_issue(0, 1, 0, 0, 'h100);  tick(); set_idle();
      drive_issue(3, 0, 0, 0, 0);      tick(); set_idle();
      drive_alu(1, 32'h11, 0); drive_lsb(3, 32'h33); tick(); set_idle();
      drive_alu(2, 0, 1); tick(); set_idle();
      chk("br_prev_commit", 32'(rob_to_rf_rob_index), 1);
      tick();
      chk("flush_lit", 32'(clr_out), 1);
      chk("flush_pc_lit", clr_pc, 32'h100);
      tick();
      chk("flush_no_tag3", 32'(rob_to_rf_ready), 0);
      chk("flush_next_tag", 32'(issue_rob_index), 1);

      // Store commit pulses both strobes.
      drive_issue(0, 0, 1, 0, 0); tick(); set_idle();
      drive_lsb(1, 32'hAB); tick(); set_idle();
      tick();
      chk("store_lsb_commit", 32'(rob_to_lsb_commit), 1);
      chk("store_rf_ready", 32'(rob_to_rf_ready), 1);

      // Stall: strobe held, ALU traffic ignored, no repeat afterwards.
      drive_issue(7, 0, 0, 0, 0); tick(); set_idle();
      drive_issue(8, 0, 0, 0, 0); tick(); set_idle();
      drive_alu(2, 32'h77, 0); tick(); set_idle();
      tick();
      for (int i = 0; i < 3; i++) begin
         rdy_in = 0;
         drive_alu(3, 32'h99, 0);
         tick();
         chk("stall_held_strobe", 32'(rob_to_rf_ready), 1);
      end
      set_idle();
      tick();
      chk("stall_no_repeat", 32'(rob_to_rf_ready), 0);
      tick();
      chk("stall_wb_dropped", 32'(rob_to_rf_ready), 0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         randomize_inputs();
         tick();
         if ($urandom_range(499) == 0) begin set_idle(); do_reset(); end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
